pipebtb: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the five-stage pipelined computer. Sits beside `pipeif`: looks up the current `pc` combinationally, predicts taken/not-taken and target, and lets IF redirect speculatively. It is updated when the branch resolves in ID. Adds dynamic prediction and mispredict/branch statistics, which the fixed PC-select path lacks.

---
 rtl/pipebtb_pkg.sv | 23 ++
 rtl/pipebtb_ctr2.sv | 27 ++
 rtl/pipebtb.sv | 99 +++++++++
 tb/tb_pipebtb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipebtb_pkg.sv
// Shared encodings and helpers for the branch target buffer.
// The 2-bit direction counter's states and its saturating step live here.
package pipebtb_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RST   = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipebtb_ctr2.sv
// One 2-bit saturating direction counter with clear, allocate-load and inc/dec.
// Clear wins over allocate, which wins over inc/dec.
module pipebtb_ctr2
  import pipebtb_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr,
  input  logic       alloc,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ctr <= CTR_RST;
    end else if (clr) begin
      ctr <= CTR_RST;
    end else if (alloc) begin
      ctr <= CTR_ALLOC;
    end else if (inc || dec) begin
      ctr <= ctr_next(ctr, inc);
    end
  end

endmodule

// File: rtl/pipebtb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational on pc; updates from the resolving stage land on the clock edge.
module pipebtb
  import pipebtb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            inv_all,
  output logic            mispredict,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, upd_en;
  logic             unused_bits;

  assign l_idx = pc[IDX_W+1:2];
  assign l_tag = pc[XLEN-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_bits = &{1'b0, pc[1:0], upd_pc[1:0]};

  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = l_hit && ctr_q[l_idx][1];
  assign pred_target = l_hit ? target_q[l_idx] : '0;

  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  // Invalidate drops the table write of a same-cycle update.
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_en = upd_valid && !inv_all;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (upd_en && upd_taken) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // A taken update always writes tag and target: on a hit the tag is unchanged.
  always_ff @(posedge clock) begin
    if (upd_en && upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_en && (u_idx == IDX_W'(i));
    pipebtb_ctr2 u_ctr (
      .clock (clock),
      .resetn(resetn),
      .clr   (inv_all),
      .alloc (sel && !u_hit && upd_taken),
      .inc   (sel && u_hit && upd_taken),
      .dec   (sel && u_hit && !upd_taken),
      .ctr   (ctr_q[i])
    );
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd_valid) begin
      branch_cnt  <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipebtb.sv
// Directed bench for pipebtb: allocation, counter hysteresis, aliasing,
// no-bypass timing, invalidate priority and asynchronous reset.
module tb_pipebtb;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        inv_all;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  pipebtb #(.ENTRIES(16), .XLEN(32)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .inv_all        (inv_all),
    .mispredict     (mispredict),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] a, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    upd_valid = v; upd_pc = a; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pc = 32'h40; inv_all = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); step();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target got %h exp 0", pred_target); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got %0d exp 0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt got %0d exp 0", mispred_cnt); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %0b exp 0", mispredict); end
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b exp 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle got %0b exp 0", pred_taken); end
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got %0b exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alloc_pred_target got %h exp 00000080", pred_target); end
    checks++; if (mispred_cnt !== 32'd1) begin errors++; $display("FAIL alloc_mispred_cnt got %0d exp 1", mispred_cnt); end
    checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL alloc_branch_cnt got %0d exp 1", branch_cnt); end
  endtask

  task automatic test_counter();
    logic exp_t [3];
    exp_t[0] = 1'b0; exp_t[1] = 1'b1; exp_t[2] = 1'b1;
    pc = 32'h40;
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      upd_valid = 1'b0;
      #1;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt_step%0d pred_taken got %0b exp 0", k, pred_taken); end
    end
    checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL nt_hit_target got %h exp 00000080", pred_target); end
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL t_step%0d mispredict got %0b exp 0", k, mispredict); end
      step();
      upd_valid = 1'b0;
      #1;
      checks++; if (pred_taken !== exp_t[k]) begin errors++; $display("FAIL t_step%0d pred_taken got %0b exp %0b", k, pred_taken, exp_t[k]); end
    end
    checks++; if (branch_cnt !== 32'd8) begin errors++; $display("FAIL ctr_branch_cnt got %0d exp 8", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd1) begin errors++; $display("FAIL ctr_mispred_cnt got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0);
    step();
    set_upd(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    upd_valid = 1'b0;
    pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL alias_old_tag got %0b/%h exp 0/00000000", pred_taken, pred_target); end
    pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hC0) begin errors++; $display("FAIL alias_new_tag got %0b/%h exp 1/000000c0", pred_taken, pred_target); end
    pc = 32'h44; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL miss_nt_no_alloc got %0b/%h exp 0/00000000", pred_taken, pred_target); end
    checks++; if (branch_cnt !== 32'd10 || mispred_cnt !== 32'd2) begin errors++; $display("FAIL alias_counts got %0d/%0d exp 10/2", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_same_cycle();
    pc = 32'h80;
    set_upd(1'b1, 32'h80, 1'b1, 32'h100, 1'b1, 32'hC0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL target_mispredict got %0b exp 1", mispredict); end
    checks++; if (pred_target !== 32'hC0) begin errors++; $display("FAIL same_cycle_old got %h exp 000000c0", pred_target); end
    step();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin errors++; $display("FAIL same_cycle_new got %0b/%h exp 1/00000100", pred_taken, pred_target); end
    checks++; if (mispred_cnt !== 32'd3) begin errors++; $display("FAIL same_cycle_mispred_cnt got %0d exp 3", mispred_cnt); end
  endtask

  task automatic test_invalidate();
    set_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h100);
    inv_all = 1'b1;
    step();
    inv_all = 1'b0; upd_valid = 1'b0;
    pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL inv_80 got %0b/%h exp 0/00000000", pred_taken, pred_target); end
    pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL inv_40 got %0b/%h exp 0/00000000", pred_taken, pred_target); end
    checks++; if (branch_cnt !== 32'd12 || mispred_cnt !== 32'd4) begin errors++; $display("FAIL inv_counts got %0d/%0d exp 12/4", branch_cnt, mispred_cnt); end
    set_upd(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    step();
    upd_valid = 1'b0;
    pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL realloc got %0b/%h exp 1/00000300", pred_taken, pred_target); end
  endtask

  task automatic test_back_to_back();
    set_upd(1'b1, 32'h48, 1'b1, 32'h10, 1'b0, 32'h0);
    step();
    set_upd(1'b1, 32'h4C, 1'b1, 32'h20, 1'b0, 32'h0);
    step();
    upd_valid = 1'b0;
    pc = 32'h48; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h10) begin errors++; $display("FAIL b2b_48 got %0b/%h exp 1/00000010", pred_taken, pred_target); end
    pc = 32'h4C; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h20) begin errors++; $display("FAIL b2b_4c got %0b/%h exp 1/00000020", pred_taken, pred_target); end
    checks++; if (branch_cnt !== 32'd15 || mispred_cnt !== 32'd7) begin errors++; $display("FAIL b2b_counts got %0d/%0d exp 15/7", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_async_reset();
    pc = 32'h48;
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL areset_pred got %0b/%h exp 0/00000000", pred_taken, pred_target); end
    checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin errors++; $display("FAIL areset_counts got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
    set_upd(1'b1, 32'h48, 1'b1, 32'h10, 1'b0, 32'h0);
    step();
    checks++; if (branch_cnt !== 32'd0 || pred_taken !== 1'b0) begin errors++; $display("FAIL areset_hold got %0d/%0b exp 0/0", branch_cnt, pred_taken); end
    upd_valid = 1'b0;
    #2 resetn = 1'b1;
    step();
    checks++; if (pred_taken !== 1'b0 || branch_cnt !== 32'd0) begin errors++; $display("FAIL areset_release got %0b/%0d exp 0/0", pred_taken, branch_cnt); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_invalidate();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
